// File: rtl/alu_pipe_stage_if.sv
// Valid/ready operand and result channels of the two-stage ALU pipeline.
// Upstream and downstream share one bundle; the DUT attaches as slave.
interface alu_pipe_stage_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             cout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, y, cout, zero, ovf
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, y, cout, zero, ovf
   );
endinterface

// File: rtl/alu_pipe_stage.sv
// Two-stage registered ALU: stage 1 captures op/a/b, stage 2 registers result and flags.
// Counts results consumed downstream.
module alu_pipe_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_pipe_stage_if.slave  bus,
   output logic [CNT_W-1:0] done_cnt
);
   typedef enum logic [2:0] {
      OP_INC   = 3'b000,
      OP_DEC   = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_AND   = 3'b100,
      OP_OR    = 3'b101,
      OP_XOR   = 3'b110,
      OP_PASSA = 3'b111
   } op_e;

   logic             r_s1_valid;
   op_e              r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_cout;
   logic             r_zero;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_adv1;
   logic             w_adv2;
   logic [WIDTH-1:0] w_opb;
   logic             w_cin;
   logic             w_arith;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_y;
   logic             w_cout;
   logic             w_ovf;

   assign w_adv2 = !r_s2_valid || bus.out_ready;
   assign w_adv1 = !r_s1_valid || w_adv2;

   // Every arithmetic op is a + opb + cin on an extended adder; opb is the effective operand.
   always_comb begin
      w_opb   = '0;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      w_y     = '0;
      unique case (r_s1_op)
         OP_INC:  begin w_opb = WIDTH'(1); w_arith = 1'b1; end
         OP_DEC:  begin w_opb = '1;        w_arith = 1'b1; end
         OP_ADD:  begin w_opb = r_s1_b;    w_arith = 1'b1; end
         OP_SUB:  begin w_opb = ~r_s1_b;   w_cin = 1'b1; w_arith = 1'b1; end
         default: ;
      endcase
      w_sum = {1'b0, r_s1_a} + {1'b0, w_opb} + (WIDTH+1)'(w_cin);
      unique case (r_s1_op)
         OP_AND:   w_y = r_s1_a & r_s1_b;
         OP_OR:    w_y = r_s1_a | r_s1_b;
         OP_XOR:   w_y = r_s1_a ^ r_s1_b;
         OP_PASSA: w_y = r_s1_a;
         default:  w_y = w_sum[WIDTH-1:0];
      endcase
      w_cout = w_arith & w_sum[WIDTH];
      w_ovf  = w_arith & (r_s1_a[WIDTH-1] == w_opb[WIDTH-1]) & (w_y[WIDTH-1] != r_s1_a[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= OP_INC;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (w_adv1) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_op <= op_e'(bus.op);
            r_s1_a  <= bus.a;
            r_s1_b  <= bus.b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_cout     <= 1'b0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_y    <= w_y;
            r_cout <= w_cout;
            r_zero <= (w_y == '0);
            r_ovf  <= w_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_s2_valid && bus.out_ready) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready  = w_adv1;
   assign bus.out_valid = r_s2_valid;
   assign bus.y         = r_y;
   assign bus.cout      = r_cout;
   assign bus.zero      = r_zero;
   assign bus.ovf       = r_ovf;
   assign done_cnt      = r_cnt;
endmodule

// File: tb/tb_alu_pipe_stage.sv
// Self-checking bench for alu_pipe_stage: directed flag cases, random streaming,
// backpressure, asynchronous reset mid-flight and counter wrap (CNT_W=4).
module tb_alu_pipe_stage;
   localparam int W  = 8;
   localparam int CW = 4;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c;
      logic         z;
      logic         v;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] done_cnt;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            exp_cnt = 0;
   res_t          q[$];

   always #5 clk = ~clk;

   alu_pipe_stage_if #(.WIDTH(W)) bus();

   alu_pipe_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .done_cnt (done_cnt)
   );

   // Reference: unsigned sum for y/cout, true signed result range for ovf.
   function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      int   ua, ub, sa, sb, full, sres;
      logic arith;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      full = 0; sres = 0; arith = 1'b1;
      r = '0;
      case (op)
         3'd0: begin full = ua + 1;              sres = sa + 1;  end
         3'd1: begin full = ua + 255;            sres = sa - 1;  end
         3'd2: begin full = ua + ub;             sres = sa + sb; end
         3'd3: begin full = ua + (255 - ub) + 1; sres = sa - sb; end
         3'd4: begin r.y = a & b; arith = 1'b0; end
         3'd5: begin r.y = a | b; arith = 1'b0; end
         3'd6: begin r.y = a ^ b; arith = 1'b0; end
         default: begin r.y = a; arith = 1'b0; end
      endcase
      if (arith) begin
         r.y = full[7:0];
         r.c = (full > 255);
         r.v = (sres > 127) || (sres < -128);
      end
      r.z = (r.y == 8'h00);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic rand_in();
      bus.op = 3'($urandom_range(0, 7));
      bus.a  = 8'($urandom);
      bus.b  = 8'($urandom);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      q.delete();
      tick();
   endtask

   task automatic test_reset();
      res_t got;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.op = '0; bus.a = '0; bus.b = '0;
      #3;
      got = {bus.y, bus.cout, bus.zero, bus.ovf};
      n_cmp++;
      if (bus.out_valid !== 1'b0 || got !== '0 || done_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_state: out_valid=%b res=%h cnt=%0d, want 0/0/0", bus.out_valid, got, done_cnt);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [2:0] ops[7] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd3, 3'd2, 3'd6};
      logic [7:0] as[7]  = '{8'hFF, 8'h7F, 8'h00, 8'h05, 8'h80, 8'h40, 8'hAA};
      logic [7:0] bs[7]  = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h01, 8'h40, 8'hAA};
      res_t e, got;
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1; bus.out_ready = 1'b0;
         bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
         e = model(ops[i], as[i], bs[i]);
         smp();
         n_cmp++;
         if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
         end
         tick();
         bus.in_valid = 1'b0;
         smp();
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dir%0d_early_valid: got %b want 0", i, bus.out_valid);
         end
         tick(); tick();
         smp();
         got = {bus.y, bus.cout, bus.zero, bus.ovf};
         n_cmp++;
         if (bus.out_valid !== 1'b1 || got !== e) begin
            n_bad++;
            $display("FAIL dir%0d_result: valid=%b y=%h c=%b z=%b v=%b, want valid=1 y=%h c=%b z=%b v=%b",
                     i, bus.out_valid, got.y, got.c, got.z, got.v, e.y, e.c, e.z, e.v);
         end
         bus.out_ready = 1'b1;
         tick();
         exp_cnt++;
         bus.out_ready = 1'b0;
         n_cmp++;
         if (done_cnt !== CW'(exp_cnt) || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dir%0d_count: cnt=%0d valid=%b, want cnt=%0d valid=0", i, done_cnt, bus.out_valid, exp_cnt % 16);
         end
      end
   endtask

   task automatic stream(input string tag, input int n);
      int   nin = 0, nout = 0, first = -1, last = -1;
      res_t e, got;
      q.delete();
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < n + 6; cyc++) begin
         if (nin < n) begin bus.in_valid = 1'b1; rand_in(); end
         else bus.in_valid = 1'b0;
         smp();
         if (bus.in_valid) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL %s_in_ready: cycle %0d got %b want 1", tag, cyc, bus.in_ready);
            end else begin
               q.push_back(model(bus.op, bus.a, bus.b));
               nin++;
            end
         end
         if (bus.out_valid) begin
            got = {bus.y, bus.cout, bus.zero, bus.ovf};
            e = (q.size() > 0) ? q.pop_front() : '1;
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL %s_result%0d: got y=%h c=%b z=%b v=%b want y=%h c=%b z=%b v=%b",
                        tag, nout, got.y, got.c, got.z, got.v, e.y, e.c, e.z, e.v);
            end
            if (first < 0) first = cyc;
            last = cyc;
            nout++;
            exp_cnt++;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (nout !== n || (last - first) !== n - 1 || done_cnt !== CW'(exp_cnt)) begin
         n_bad++;
         $display("FAIL %s_totals: got out=%0d span=%0d cnt=%0d want out=%0d span=%0d cnt=%0d",
                  tag, nout, last - first, done_cnt, n, n - 1, exp_cnt % 16);
      end
   endtask

   task automatic test_back_to_back();
      stream("b2b", 10);
   endtask

   task automatic test_backpressure();
      int   acc = 0, got_n = 0;
      res_t e, got;
      q.delete();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      rand_in();
      for (int cyc = 0; cyc < 6; cyc++) begin
         smp();
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.op, bus.a, bus.b));
            acc++;
            tick();
            rand_in();
         end else tick();
      end
      smp();
      n_cmp++;
      if (acc !== 2 || bus.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_accept: got accepted=%0d in_ready=%b want 2/0", acc, bus.in_ready);
      end
      tick();
      e = (q.size() > 0) ? q[0] : '1;
      for (int i = 0; i < 5; i++) begin
         smp();
         got = {bus.y, bus.cout, bus.zero, bus.ovf};
         n_cmp++;
         if (bus.out_valid !== 1'b1 || got !== e) begin
            n_bad++;
            $display("FAIL bp_hold%0d: valid=%b res=%h want 1/%h", i, bus.out_valid, got, e);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         smp();
         if (bus.out_valid) begin
            got = {bus.y, bus.cout, bus.zero, bus.ovf};
            e = (q.size() > 0) ? q.pop_front() : '1;
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL bp_drain%0d: got %h want %h", got_n, got, e);
            end
            got_n++;
            exp_cnt++;
         end
         tick();
      end
      n_cmp++;
      if (got_n !== 2 || done_cnt !== CW'(exp_cnt)) begin
         n_bad++;
         $display("FAIL bp_drain_total: got out=%0d cnt=%0d want 2/%0d", got_n, done_cnt, exp_cnt % 16);
      end
   endtask

   task automatic test_reset_midflight();
      int   acc = 0;
      logic found = 1'b0;
      res_t e, got;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      rand_in();
      for (int cyc = 0; cyc < 6 && acc < 2; cyc++) begin
         smp();
         if (bus.in_ready) acc++;
         tick();
         rand_in();
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      got = {bus.y, bus.cout, bus.zero, bus.ovf};
      n_cmp++;
      if (acc !== 2 || bus.out_valid !== 1'b0 || got !== '0 || done_cnt !== '0) begin
         n_bad++;
         $display("FAIL async_reset: acc=%0d valid=%b res=%h cnt=%0d want 2/0/0/0", acc, bus.out_valid, got, done_cnt);
      end
      exp_cnt = 0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         smp();
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_ghost%0d: valid=%b want 0", i, bus.out_valid);
         end
         tick();
      end
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      rand_in();
      e = model(bus.op, bus.a, bus.b);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         smp();
         if (bus.out_valid) begin
            found = 1'b1;
            got = {bus.y, bus.cout, bus.zero, bus.ovf};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL post_reset_result: got %h want %h", got, e);
            end
            exp_cnt++;
         end
         tick();
      end
      n_cmp++;
      if (!found || done_cnt !== CW'(exp_cnt)) begin
         n_bad++;
         $display("FAIL post_reset_done: found=%b cnt=%0d want 1/%0d", found, done_cnt, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      stream("wrap", 17);
      n_cmp++;
      if (done_cnt !== 4'd1) begin
         n_bad++;
         $display("FAIL cnt_wrap: got %0d want 1", done_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
